// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// Used by both uart_rx and the existing transmitter.
package uart_pkg;

    // 27 MHz system clock at 9600 baud
    localparam int UART_CLKS_PER_BIT = 2812;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// The reset value lets idle-high lines come out of reset without a false edge.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / frame_err pulses.
// All outputs are registered; rx only reaches the logic through sync_2ff.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | line idle, waiting for rx_s low
// ST_START | half-bit wait, then confirm start bit (high = glitch)
// ST_DATA  | one bit period per data bit, LSB first into shift reg
// ST_STOP  | one bit period, then check stop bit
// ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    logic              rx_s;
    uart_state_t       state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [2:0]        idx, idx_nxt;
    logic [7:0]        shreg, shreg_nxt;
    logic [7:0]        data_nxt;
    logic              valid_nxt;
    logic              ferr_nxt;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync_rx (
        .clk(clk),
        .rst(rst),
        .d  (rx),
        .q  (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            shreg     <= shreg_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!rx_s) begin
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt        = '0;
                    shreg_nxt[idx] = rx_s;
                    idx_nxt        = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt == CNT_FULL) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            // a held-low line must not be mistaken for a new start bit
            ST_BREAK: begin
                cnt_nxt = '0;
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor logs pulses
// and received bytes, and immediate assertions compare against hand-computed values.
module tb_uart_rx;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          compared   = 0;
    int          mismatched = 0;
    int          valid_cnt  = 0;
    int          ferr_cnt   = 0;
    int          both_cnt   = 0;
    int          wide_cnt   = 0;
    int unsigned last_valid_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  rx_q[$];

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_q.push_back(data);
            last_valid_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) both_cnt++;
        if (valid && prev_valid) wide_cnt++;
        prev_valid = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d",
                 compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        settle();
        valid_cnt = 0;
        ferr_cnt  = 0;
        rx_q.delete();
        @(negedge clk);
    endtask

    task automatic bit_time();
        repeat (C) @(negedge clk);
    endtask

    // must be entered at a negedge; leaves rx at the stop level
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bit_time();
        end
        rx = stop;
        bit_time();
    endtask

    task automatic check_next(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'hxx;
        if (rx_q.size() > 0) got = rx_q.pop_front();
        check(tag, {24'h0, got}, {24'h0, exp});
    endtask

    int unsigned t0;
    int unsigned lat;
    logic        fell;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        settle();
        check("reset_data",  {24'h0, data}, 32'h0);
        check("reset_valid", {31'h0, valid}, 32'h0);
        check("reset_ferr",  {31'h0, frame_err}, 32'h0);
        check("reset_busy",  {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single good frame and its latency from the start edge
        clear_mon();
        t0 = cyc;
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        settle();
        lat = last_valid_cyc - t0;
        check("a5_valid_cnt", valid_cnt, 32'd1);
        check("a5_data", {24'h0, data}, 32'hA5);
        check_next("a5_q", 8'hA5);
        check("a5_ferr", ferr_cnt, 32'd0);
        check("a5_latency_window", {31'h0, (lat >= 153 && lat <= 155)}, 32'd1);
        check("a5_idle_busy", {31'h0, busy}, 32'h0);

        // 4-cycle start glitch
        clear_mon();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_rise", {31'h0, busy}, 32'h1);
        fell = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy) begin
                fell = 1'b1;
                break;
            end
        end
        check("glitch_busy_fall", {31'h0, fell}, 32'h1);
        repeat (2 * C) @(negedge clk);
        settle();
        check("glitch_valid_cnt", valid_cnt, 32'd0);
        check("glitch_ferr_cnt", ferr_cnt, 32'd0);

        // good 0x11, then 0x3C with a low stop bit and a held-low line
        clear_mon();
        send_byte(8'h11, 1'b1);
        settle();
        check("g11_data", {24'h0, data}, 32'h11);
        @(negedge clk);
        send_byte(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        settle();
        check("brk_busy_held", {31'h0, busy}, 32'h1);
        check("brk_ferr_cnt", ferr_cnt, 32'd1);
        check("brk_data_kept", {24'h0, data}, 32'h11);
        check("brk_valid_cnt", valid_cnt, 32'd1);
        @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        settle();
        check("brk_busy_release", {31'h0, busy}, 32'h0);
        repeat (2 * C) @(negedge clk);

        // back-to-back frames with no idle gap
        clear_mon();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        settle();
        check("b2b_valid_cnt", valid_cnt, 32'd2);
        check_next("b2b_first", 8'h00);
        check_next("b2b_second", 8'hFF);
        check("b2b_ferr_cnt", ferr_cnt, 32'd0);

        // reset during data bit 3, then a clean frame
        clear_mon();
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < 3; i++) begin
            rx = ~i[0];
            bit_time();
        end
        rx = 1'b0;
        repeat (C / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        settle();
        check("rstmid_data",  {24'h0, data}, 32'h0);
        check("rstmid_valid", {31'h0, valid}, 32'h0);
        check("rstmid_ferr",  {31'h0, frame_err}, 32'h0);
        check("rstmid_busy",  {31'h0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        settle();
        check("rstmid_no_pulse", valid_cnt + ferr_cnt, 32'd0);
        @(negedge clk);
        send_byte(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        settle();
        check("post_rst_valid_cnt", valid_cnt, 32'd1);
        check("post_rst_data", {24'h0, data}, 32'h5A);
        check_next("post_rst_q", 8'h5A);
        check("post_rst_ferr", ferr_cnt, 32'd0);

        // all byte values back to back
        clear_mon();
        for (int b = 0; b < 256; b++) begin
            send_byte(8'(b), 1'b1);
        end
        repeat (4) @(negedge clk);
        settle();
        check("loop_valid_cnt", valid_cnt, 32'd256);
        check("loop_ferr_cnt", ferr_cnt, 32'd0);
        for (int b = 0; b < 256; b++) begin
            check_next($sformatf("loop_byte_%0d", b), 8'(b));
        end

        check("never_valid_and_ferr", both_cnt, 32'd0);
        check("valid_single_cycle", wide_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_uart_rx
